// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings, counter width and saturating-increment helper for the
// pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'b00,
    StDmemWait = 2'b01,
    StRedirect = 2'b10,
    StHalt     = 2'b11
  } ctrlState_e;

  localparam int unsigned CntWidth = 16;

  function automatic logic [CntWidth-1:0] satInc(input logic [CntWidth-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Event inputs and latch-control outputs of the stall/flush sequencer.
// master = pipeline side (drives events), slave = the sequencer.
interface pipe_stall_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                imem_stall;
  logic                dmem_req;
  logic                dmem_done;
  logic                load_use;
  logic                branch_taken;
  logic                halt_req;

  logic                pc_en;
  logic                ifid_en;
  logic                idex_en;
  logic                exmem_en;
  logic                memwb_en;
  logic                ifid_bubble;
  logic                idex_bubble;
  logic                exmem_bubble;
  logic                memwb_bubble;
  logic                halted;
  logic [1:0]          ctrl_state;
  logic [CntWidth-1:0] stall_cycles;
  logic [CntWidth-1:0] flush_count;

  modport master (
    output imem_stall, dmem_req, dmem_done, load_use, branch_taken, halt_req,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble,
    input  halted, ctrl_state, stall_cycles, flush_count
  );

  modport slave (
    input  imem_stall, dmem_req, dmem_done, load_use, branch_taken, halt_req,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble,
    output halted, ctrl_state, stall_cycles, flush_count
  );

endinterface

// File: rtl/sat_counter16.sv
// Saturating up-counter: cleared by reset, increments while en, sticks at all-ones.
module sat_counter16
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [CntWidth-1:0] count
);

  logic [CntWidth-1:0] countQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countQ <= '0;
    end else if (en) begin
      countQ <= satInc(countQ);
    end
  end

  assign count = countQ;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: Mealy latch enables and bubbles.
// Perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  pipe_stall_ctrl_if.slave bus
);

  ctrlState_e stateQ, stateD;

  logic pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic ifidBub, idexBub, exmemBub, memwbBub;
  logic flushHit;
  logic dmemBusy;

  assign dmemBusy = bus.dmem_req & ~bus.dmem_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StRun;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StRun: begin
        if (bus.halt_req) begin
          stateD = StHalt;
        end else if (dmemBusy) begin
          stateD = StDmemWait;
        end else if (bus.branch_taken && bus.imem_stall) begin
          stateD = StRedirect;
        end
      end
      StDmemWait: if (bus.dmem_done) stateD = StRun;
      StRedirect: if (!bus.imem_stall) stateD = StRun;
      StHalt:     stateD = StHalt;
      default:    stateD = StRun;
    endcase
  end

  always_comb begin
    pcEn     = 1'b1;
    ifidEn   = 1'b1;
    idexEn   = 1'b1;
    exmemEn  = 1'b1;
    memwbEn  = 1'b1;
    ifidBub  = 1'b0;
    idexBub  = 1'b0;
    exmemBub = 1'b0;
    memwbBub = 1'b0;
    flushHit = 1'b0;
    case (stateQ)
      StRun: begin
        if (bus.halt_req) begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = '0;
        end else if (dmemBusy) begin
          {pcEn, ifidEn, idexEn, exmemEn} = '0;
          memwbBub = 1'b1;
        end else if (bus.branch_taken) begin
          {ifidBub, idexBub, exmemBub} = '1;
          flushHit = 1'b1;
        end else if (bus.load_use) begin
          pcEn    = 1'b0;
          ifidEn  = 1'b0;
          idexBub = 1'b1;
        end else if (bus.imem_stall) begin
          pcEn    = 1'b0;
          ifidBub = 1'b1;
        end
      end
      StDmemWait: begin
        if (!bus.dmem_done) begin
          {pcEn, ifidEn, idexEn, exmemEn} = '0;
          memwbBub = 1'b1;
        end
      end
      StRedirect: begin
        // The wrong-path word is squashed both while in flight and when it lands.
        pcEn    = ~bus.imem_stall;
        ifidBub = 1'b1;
      end
      default: begin
        {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = '0;
      end
    endcase
    if (rst) begin
      {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = '0;
      {ifidBub, idexBub, exmemBub, memwbBub}   = '0;
      flushHit = 1'b0;
    end
  end

  assign bus.pc_en        = pcEn;
  assign bus.ifid_en      = ifidEn;
  assign bus.idex_en      = idexEn;
  assign bus.exmem_en     = exmemEn;
  assign bus.memwb_en     = memwbEn;
  assign bus.ifid_bubble  = ifidBub;
  assign bus.idex_bubble  = idexBub;
  assign bus.exmem_bubble = exmemBub;
  assign bus.memwb_bubble = memwbBub;
  assign bus.halted       = (stateQ == StHalt);
  assign bus.ctrl_state   = stateQ;

`ifdef PIPE_PERF_CNT_EN
  logic stallInc;
  assign stallInc = ~pcEn & (stateQ != StHalt);

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stallInc),
    .count (bus.stall_cycles)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flushHit),
    .count (bus.flush_count)
  );
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios plus random events
// checked against a behavioural pipeline-event model.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // en = {pc, ifid, idex, exmem, memwb}; bub = {ifid, idex, exmem, memwb}
  typedef struct {
    logic [4:0]  en;
    logic [3:0]  bub;
    logic        halted;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Model: what the pipeline is currently waiting on, plus plain integer counters.
  bit mWaitingDmem, mFetchInFlight, mHalted;
  int mStall, mFlush;
  bit perfOn;

  initial begin
`ifdef PIPE_PERF_CNT_EN
    perfOn = 1'b1;
`else
    perfOn = 1'b0;
`endif
  end

  function automatic exp_t modelStep(input bit imem, input bit dreq, input bit ddone,
                                     input bit lu, input bit br, input bit hr, input bit r);
    exp_t e;
    e.en = 5'b11111;
    e.bub = 4'b0000;
    if (r) begin
      mWaitingDmem = 0; mFetchInFlight = 0; mHalted = 0; mStall = 0; mFlush = 0;
      e.en = 0; e.bub = 0; e.halted = 0; e.st = 0; e.stall = 0; e.flush = 0;
      return e;
    end
    e.halted = mHalted;
    e.st     = mHalted ? 2'd3 : mWaitingDmem ? 2'd1 : mFetchInFlight ? 2'd2 : 2'd0;
    e.stall  = perfOn ? 16'(mStall) : 16'h0;
    e.flush  = perfOn ? 16'(mFlush) : 16'h0;
    if (mHalted) begin
      e.en = 0;
    end else if (mWaitingDmem) begin
      if (!ddone) begin
        e.en = 5'b00001; e.bub = 4'b0001;
      end else begin
        mWaitingDmem = 0;
      end
    end else if (mFetchInFlight) begin
      e.en[4] = !imem;
      e.bub = 4'b1000;
      if (!imem) mFetchInFlight = 0;
    end else if (hr) begin
      e.en = 0; mHalted = 1;
    end else if (dreq && !ddone) begin
      e.en = 5'b00001; e.bub = 4'b0001; mWaitingDmem = 1;
    end else if (br) begin
      e.bub = 4'b1110;
      if (mFlush < 65535) mFlush++;
      mFetchInFlight = imem;
    end else if (lu) begin
      e.en = 5'b00111; e.bub = 4'b0100;
    end else if (imem) begin
      e.en = 5'b01111; e.bub = 4'b1000;
    end
    if (!e.en[4] && !e.halted && mStall < 65535) mStall++;
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("enables", 16'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}),
            16'(e.en));
      check("bubbles", 16'({bus.ifid_bubble, bus.idex_bubble, bus.exmem_bubble,
                            bus.memwb_bubble}), 16'(e.bub));
      check("halted", 16'(bus.halted), 16'(e.halted));
      check("ctrl_state", 16'(bus.ctrl_state), 16'(e.st));
      check("stall_cycles", bus.stall_cycles, e.stall);
      check("flush_count", bus.flush_count, e.flush);
    end
  end

  task automatic step(input bit imem, input bit dreq, input bit ddone, input bit lu,
                      input bit br, input bit hr, input bit r = 1'b0);
    @(posedge clk);
    #1;
    rst              = r;
    bus.imem_stall   = imem;
    bus.dmem_req     = dreq;
    bus.dmem_done    = ddone;
    bus.load_use     = lu;
    bus.branch_taken = br;
    bus.halt_req     = hr;
    expQ.push_back(modelStep(imem, dreq, ddone, lu, br, hr, r));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stimulus
    bit imem, dreq, ddone, lu, br;
    exp_t junk;
    bus.imem_stall = 0; bus.dmem_req = 0; bus.dmem_done = 0;
    bus.load_use = 0; bus.branch_taken = 0; bus.halt_req = 0;

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // load-use
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    // data stall, then release
    repeat (4) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    idle(2);
    // redirect while fetch busy, then with idle imem
    step(1, 0, 0, 0, 1, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(2);
    // data stall beats branch; branch applied after dmem_done
    repeat (2) step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(1);
    // reset mid-DMEM_WAIT and mid-REDIRECT
    repeat (2) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    idle(2);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(0, 0, 0, 0, 0, 0, 1);
        continue;
      end
      imem  = ($urandom_range(0, 2) == 0);
      lu    = ($urandom_range(0, 4) == 0);
      br    = ($urandom_range(0, 5) == 0) && !mFetchInFlight;
      ddone = ($urandom_range(0, 2) == 0);
      if (mFetchInFlight)    dreq = 0;
      else if (mWaitingDmem) dreq = 1;
      else                   dreq = ($urandom_range(0, 5) == 0);
      step(imem, dreq, ddone, lu, br, 0);
    end

    // counter saturation
    step(0, 0, 0, 0, 0, 0, 1);
    if (perfOn) begin
      for (int i = 0; i < 70000; i++) step(1, 0, 0, 0, 0, 0);
    end else begin
      for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0, 0);
    end
    idle(2);

    // halt is sticky regardless of inputs
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end
    // asynchronous reset mid-cycle zeroes outputs at once
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    junk = modelStep(0, 0, 0, 0, 0, 0, 1);
    check("async_rst_en", 16'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                               bus.memwb_en}), 16'(junk.en));
    check("async_rst_bub", 16'({bus.ifid_bubble, bus.idex_bubble, bus.exmem_bubble,
                                bus.memwb_bubble}), 16'(junk.bub));
    check("async_rst_halted", 16'(bus.halted), 16'(junk.halted));
    check("async_rst_state", 16'(bus.ctrl_state), 16'(junk.st));
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 1, 0, 0);
    idle(2);

    @(posedge clk);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
